// File: rtl/spi_tx_frame_feeder_pkg.sv
// Shared definitions for the SPI TX frame feeder.
//   state_e      : FSM state encoding (IDLE/SETUP/STROBE/GAP)
//   DEF_*        : default frame size and phase timing, in Mclk cycles
//   frame_w()    : frame width in bits for a given byte count
//   max3()       : largest of three phase lengths, used to size the phase counter
//   cnt_width()  : counter width for a count range, never narrower than 1 bit
package spi_tx_frame_feeder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_GAP    = 2'd3
  } state_e;

  localparam int DEF_NUM_BYTES  = 15;
  localparam int DEF_SETUP_CYC  = 5;
  localparam int DEF_STROBE_CYC = 256;
  localparam int DEF_GAP_CYC    = 256;
  localparam int DEF_FRAME_W    = 8 * DEF_NUM_BYTES;

  function automatic int frame_w(input int num_bytes);
    return 8 * num_bytes;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spi_phase_timer.sv
// Loadable down-counter with terminal-count flag, shared by all three byte phases.
// Loading N-1 on phase entry makes tc rise on the N-th cycle of the phase.
//   clk      : clock
//   rst      : synchronous active-high reset (count cleared)
//   load     : load load_val this cycle (takes priority over counting)
//   load_val : value loaded into the counter
//   tc       : high while the count is zero
module spi_phase_timer
  import spi_tx_frame_feeder_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             tc
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/spi_tx_frame_feeder.sv
// Feeds one latched frame byte by byte to the SPI master as BUS_IN plus an
// active-low Data_Available strobe. Each byte: SETUP (strobe high, byte stable),
// STROBE (strobe low), GAP (strobe high); bytes follow with no idle cycles.
//   Mclk           : clock
//   Reset          : synchronous active-high reset
//   Frame_In       : frame, byte 0 in the top 8 bits
//   Frame_Valid    : frame offer, taken when Frame_Ready
//   Frame_Ready    : high in IDLE only
//   Abort          : cancel the frame in progress (wins over Frame_Valid in IDLE)
//   BUS_IN         : current byte, registered
//   Data_Available : active-low byte strobe, registered, idles high
//   Busy           : high outside IDLE
//   Done           : one-cycle pulse after the last byte's GAP
module spi_tx_frame_feeder
  import spi_tx_frame_feeder_pkg::*;
#(
  parameter int NUM_BYTES  = DEF_NUM_BYTES,
  parameter int SETUP_CYC  = DEF_SETUP_CYC,
  parameter int STROBE_CYC = DEF_STROBE_CYC,
  parameter int GAP_CYC    = DEF_GAP_CYC
) (
  input  logic                       Mclk,
  input  logic                       Reset,
  input  logic [8*NUM_BYTES-1:0]     Frame_In,
  input  logic                       Frame_Valid,
  output logic                       Frame_Ready,
  input  logic                       Abort,
  output logic [7:0]                 BUS_IN,
  output logic                       Data_Available,
  output logic                       Busy,
  output logic                       Done
);

  localparam int FRAME_W = frame_w(NUM_BYTES);
  localparam int CNT_W   = cnt_width(max3(SETUP_CYC, STROBE_CYC, GAP_CYC));
  localparam int IDX_W   = cnt_width(NUM_BYTES);

  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LD    = CNT_W'(GAP_CYC - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_BYTES - 1);

  state_e             state, state_nxt;
  logic [IDX_W-1:0]   idx;
  logic [FRAME_W-1:0] shreg;
  logic               da_q;
  logic               done_q;

  logic               tmr_load;
  logic [CNT_W-1:0]   tmr_val;
  logic               tmr_tc;
  logic               accept;
  logic               advance;
  logic               finish;

  spi_phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk      (Mclk),
    .rst      (Reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tc       (tmr_tc)
  );

  always_comb begin
    state_nxt = state;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    accept    = 1'b0;
    advance   = 1'b0;
    finish    = 1'b0;
    if (state != ST_IDLE && Abort) begin
      state_nxt = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (Frame_Valid && !Abort) begin
            accept    = 1'b1;
            state_nxt = ST_SETUP;
            tmr_load  = 1'b1;
            tmr_val   = SETUP_LD;
          end
        end
        ST_SETUP: begin
          if (tmr_tc) begin
            state_nxt = ST_STROBE;
            tmr_load  = 1'b1;
            tmr_val   = STROBE_LD;
          end
        end
        ST_STROBE: begin
          if (tmr_tc) begin
            state_nxt = ST_GAP;
            tmr_load  = 1'b1;
            tmr_val   = GAP_LD;
          end
        end
        ST_GAP: begin
          if (tmr_tc) begin
            if (idx == LAST_IDX) begin
              finish    = 1'b1;
              state_nxt = ST_IDLE;
            end else begin
              advance   = 1'b1;
              state_nxt = ST_SETUP;
              tmr_load  = 1'b1;
              tmr_val   = SETUP_LD;
            end
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Registered outputs: strobe level follows the state being entered, and
  // BUS_IN is the top byte of the shift register, so nothing reaches the
  // outputs combinationally from the inputs.
  always_ff @(posedge Mclk) begin
    if (Reset) begin
      state  <= ST_IDLE;
      idx    <= '0;
      shreg  <= '0;
      da_q   <= 1'b1;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      da_q   <= (state_nxt != ST_STROBE);
      done_q <= finish;
      if (accept) begin
        shreg <= Frame_In;
        idx   <= '0;
      end else if (advance) begin
        shreg <= shreg << 8;
        idx   <= idx + 1'b1;
      end
    end
  end

  assign BUS_IN         = shreg[FRAME_W-1 -: 8];
  assign Data_Available = da_q;
  assign Done           = done_q;
  assign Frame_Ready    = (state == ST_IDLE);
  assign Busy           = (state != ST_IDLE);

endmodule

// File: tb/tb_spi_tx_frame_feeder.sv
module tb_spi_tx_frame_feeder;

  localparam int NB       = 15;
  localparam int BYTE_CYC = 5 + 256 + 256;

  localparam logic [119:0] F1 = 120'h3FA0BCFADFE341_0021BBC9FAE25A1F;
  localparam logic [119:0] F2 = 120'h2F9009_1122334455_66778899AABB45;
  localparam logic [119:0] F3 = 120'h0102030405060708090A0B0C0D0E0F;
  localparam logic [119:0] F4 = 120'hF0E1D2C3B4A5968778695A4B3C2D1E;

  logic         Mclk;
  logic         Reset;
  logic [119:0] Frame_In;
  logic         Frame_Valid;
  logic         Frame_Ready;
  logic         Abort;
  logic [7:0]   BUS_IN;
  logic         Data_Available;
  logic         Busy;
  logic         Done;

  int total;
  int nbad;

  spi_tx_frame_feeder dut (
    .Mclk           (Mclk),
    .Reset          (Reset),
    .Frame_In       (Frame_In),
    .Frame_Valid    (Frame_Valid),
    .Frame_Ready    (Frame_Ready),
    .Abort          (Abort),
    .BUS_IN         (BUS_IN),
    .Data_Available (Data_Available),
    .Busy           (Busy),
    .Done           (Done)
  );

  initial Mclk = 1'b0;
  always #5 Mclk = ~Mclk;

  function automatic logic [7:0] byte_of(input logic [119:0] f, input int b);
    return f[8*(NB-1-b) +: 8];
  endfunction

  // Compare {BUS_IN, Data_Available, Frame_Ready, Busy, Done} at the current sample point.
  task automatic check_out(input string tag, input logic [7:0] bus, input logic da,
                           input logic fr, input logic busy, input logic done);
    logic [11:0] obs;
    logic [11:0] req;
    obs = {BUS_IN, Data_Available, Frame_Ready, Busy, Done};
    req = {bus, da, fr, busy, done};
    total++;
    assert (obs === req) else begin
      nbad++;
      $error("FAIL %s: observed bus/da/fr/busy/done=%h/%b/%b/%b/%b required %h/%b/%b/%b/%b",
             tag, obs[11:4], obs[3], obs[2], obs[1], obs[0],
             req[11:4], req[3], req[2], req[1], req[0]);
    end
  endtask

  // Follows nb bytes of frame f cycle by cycle (last byte only for last_cyc cycles).
  // On the first cycle Frame_In/Frame_Valid are set to next_in/hold; when not
  // holding, Frame_In is scrambled at every later byte to show it is ignored.
  task automatic run_bytes(input string tag, input logic [119:0] f, input int nb,
                           input int last_cyc, input logic [119:0] next_in, input bit hold);
    for (int b = 0; b < nb; b++) begin
      int         ncyc;
      int         first_bad;
      logic [7:0] eb;
      logic [7:0] bad_bus;
      logic       bad_da;
      logic       da_exp;
      logic [127:0] rnd;
      ncyc      = (b == nb - 1) ? last_cyc : BYTE_CYC;
      first_bad = -1;
      eb        = byte_of(f, b);
      bad_bus   = 8'h00;
      bad_da    = 1'b0;
      for (int c = 0; c < ncyc; c++) begin
        @(negedge Mclk);
        if (b == 0 && c == 0) begin
          Frame_In    = next_in;
          Frame_Valid = hold;
        end else if (c == 0 && !hold) begin
          rnd      = {$urandom, $urandom, $urandom, $urandom};
          Frame_In = rnd[119:0];
        end
        da_exp = !(c >= 5 && c < 5 + 256);
        if (first_bad < 0 &&
            (BUS_IN !== eb || Data_Available !== da_exp || Busy !== 1'b1 ||
             Frame_Ready !== 1'b0 || Done !== 1'b0)) begin
          first_bad = c;
          bad_bus   = BUS_IN;
          bad_da    = Data_Available;
        end
      end
      total++;
      assert (first_bad === -1) else begin
        nbad++;
        $error("FAIL %s byte%0d: first wrong cycle=%0d observed bus=%h da=%b required bus=%h",
               tag, b, first_bad, bad_bus, bad_da, eb);
      end
    end
  endtask

  initial begin
    total       = 0;
    nbad        = 0;
    Reset       = 1'b1;
    Frame_In    = '0;
    Frame_Valid = 1'b0;
    Abort       = 1'b0;

    // Reset held for three cycles
    repeat (3) @(negedge Mclk);
    check_out("reset", 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    Reset = 1'b0;
    @(negedge Mclk);
    check_out("idle", 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);

    // Abort together with Frame_Valid in IDLE: no accept
    Frame_In    = F1;
    Frame_Valid = 1'b1;
    Abort       = 1'b1;
    @(negedge Mclk);
    check_out("abort_idle", 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    Abort = 1'b0;

    // Full frame F1, Frame_In scrambled while busy
    run_bytes("f1", F1, NB, BYTE_CYC, F1, 1'b0);
    @(negedge Mclk);
    check_out("f1_done", 8'h1F, 1'b1, 1'b1, 1'b0, 1'b1);
    @(negedge Mclk);
    check_out("f1_after", 8'h1F, 1'b1, 1'b1, 1'b0, 1'b0);

    // Frame_Valid held high: second frame taken in the Done cycle
    Frame_In    = F3;
    Frame_Valid = 1'b1;
    run_bytes("f3", F3, NB, BYTE_CYC, F4, 1'b1);
    @(negedge Mclk);
    check_out("f3_done", 8'h0F, 1'b1, 1'b1, 1'b0, 1'b1);
    run_bytes("f4", F4, NB, BYTE_CYC, F4, 1'b0);
    @(negedge Mclk);
    check_out("f4_done", 8'h1E, 1'b1, 1'b1, 1'b0, 1'b1);
    @(negedge Mclk);
    check_out("f4_after", 8'h1E, 1'b1, 1'b1, 1'b0, 1'b0);

    // Abort during STROBE of byte 4
    Frame_In    = F1;
    Frame_Valid = 1'b1;
    run_bytes("f1_abort", F1, 5, 100, F1, 1'b0);
    Abort = 1'b1;
    @(negedge Mclk);
    check_out("abort", 8'hDF, 1'b1, 1'b1, 1'b0, 1'b0);
    Abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge Mclk);
      check_out("abort_idle_after", 8'hDF, 1'b1, 1'b1, 1'b0, 1'b0);
    end

    // Clean frame after the abort
    Frame_In    = F2;
    Frame_Valid = 1'b1;
    run_bytes("f2", F2, NB, BYTE_CYC, F2, 1'b0);
    @(negedge Mclk);
    check_out("f2_done", 8'h45, 1'b1, 1'b1, 1'b0, 1'b1);
    @(negedge Mclk);
    check_out("f2_after", 8'h45, 1'b1, 1'b1, 1'b0, 1'b0);

    // Reset during GAP of byte 10
    Frame_In    = F1;
    Frame_Valid = 1'b1;
    run_bytes("f1_reset", F1, 11, 300, F1, 1'b0);
    Reset = 1'b1;
    @(negedge Mclk);
    check_out("reset_mid", 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    Reset = 1'b0;
    @(negedge Mclk);
    check_out("reset_mid_after", 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, nbad);
    $finish;
  end

endmodule
